boot_loader: RTL and testbench

- Parametrised byte-stream boot loader for the CPU top. Sits between the UART byte PHY (rx strobe in, tx valid/ready out) and program memory.
- Runs the host handshake in order: send sync byte, receive 4-byte image size, receive the image, assemble it into words, write it to program memory, send ack byte.
- Generalises the fixed 32-bit, single-order loader: configurable word width, byte order, memory depth and handshake bytes, plus size validation and restartable boot.

---
 rtl/boot_loader_pkg.sv | 19 +
 rtl/boot_loader_word_assembler.sv | 55 +++++
 rtl/boot_loader.sv | 138 +++++++++++++
 tb/tb_boot_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_SYNC,
        RECV_SIZE,
        CHECK_SIZE,
        RECV_DATA,
        SEND_ACK,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned SIZE_BYTES        = 4;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'h99;
    localparam logic [7:0]  DEFAULT_ACK_BYTE  = 8'hAA;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs received bytes into program words; word_valid pulses for one cycle
// after the last byte of each word, with word holding the assembled value.
module boot_loader_word_assembler #(
    parameter int unsigned WORD_BYTES = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word
);

    localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0]        count;
    logic [8*WORD_BYTES-1:0] shift;
    logic [8*WORD_BYTES-1:0] merged;
    logic                    last;
    int unsigned             lane;

    assign last = (count == CNT_W'(WORD_BYTES - 1));

    // The incoming byte is merged combinationally so the completed word can be
    // registered on the same edge that accepts its final byte.
    always_comb begin
        lane   = 32'(count);
        merged = shift;
        if (BIG_ENDIAN) begin
            lane = WORD_BYTES - 1 - 32'(count);
        end
        merged[8*lane +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count      <= '0;
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && last;
            if (byte_valid) begin
                shift <= merged;
                count <= last ? '0 : count + 1'b1;
                if (last) begin
                    word <= merged;
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: sync handshake, size receive and validation,
// image write into program memory, then ack. Restartable from DONE/ERROR.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE   = DEFAULT_ACK_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    prog_we,
    output logic [ADDR_WIDTH-1:0]   prog_addr,
    output logic [8*WORD_BYTES-1:0] prog_wdata,
    output logic                    busy,
    output logic                    boot_done,
    output logic                    size_error
);

    localparam int unsigned LANE_SHIFT = $clog2(WORD_BYTES);
    localparam int unsigned SCNT_W     = $clog2(SIZE_BYTES);
    localparam logic [31:0] LANE_MASK  = 32'(WORD_BYTES - 1);
    localparam logic [32:0] CAPACITY   = 33'(1) << ADDR_WIDTH;

    state_t              state, state_next;
    logic [31:0]         size;
    logic [SCNT_W-1:0]   size_cnt;
    logic [31:0]         word_count;
    logic [ADDR_WIDTH:0] addr;
    logic [ADDR_WIDTH:0] words;
    logic                misaligned, too_big, transfer, restart;
    logic                byte_accept, word_valid;
    logic                tx_valid_next, busy_next, boot_done_next, size_error_next;
    logic [7:0]          tx_data_next;

    assign word_count = size >> LANE_SHIFT;
    assign misaligned = (size & LANE_MASK) != '0;
    assign too_big    = {1'b0, word_count} > CAPACITY;
    assign transfer   = tx_valid && tx_ready;
    assign restart    = start && (state == DONE || state == ERROR);
    // A byte arriving on the edge that leaves RECV_DATA is dropped.
    assign byte_accept = rx_valid && (state == RECV_DATA) && (state_next == RECV_DATA);

    assign prog_we   = word_valid;
    assign prog_addr = addr[ADDR_WIDTH-1:0];

    boot_loader_word_assembler #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (byte_accept),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (prog_wdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = SEND_SYNC;
            SEND_SYNC:  if (transfer) state_next = RECV_SIZE;
            RECV_SIZE:  if (rx_valid && size_cnt == SCNT_W'(SIZE_BYTES - 1)) state_next = CHECK_SIZE;
            CHECK_SIZE: begin
                if (misaligned || too_big) begin
                    state_next = ERROR;
                end else if (size == '0) begin
                    state_next = SEND_ACK;
                end else begin
                    state_next = RECV_DATA;
                end
            end
            RECV_DATA:  if (word_valid && (addr + 1'b1) == words) state_next = SEND_ACK;
            SEND_ACK:   if (transfer) state_next = DONE;
            DONE:       if (start) state_next = SEND_SYNC;
            ERROR:      if (start) state_next = SEND_SYNC;
            default:    state_next = IDLE;
        endcase

        tx_valid_next   = (state_next == SEND_SYNC) || (state_next == SEND_ACK);
        tx_data_next    = '0;
        if (state_next == SEND_SYNC) tx_data_next = SYNC_BYTE;
        if (state_next == SEND_ACK)  tx_data_next = ACK_BYTE;
        busy_next       = !(state_next == IDLE || state_next == DONE || state_next == ERROR);
        boot_done_next  = (state_next == DONE);
        size_error_next = (state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            boot_done  <= 1'b0;
            size_error <= 1'b0;
            size       <= '0;
            size_cnt   <= '0;
            addr       <= '0;
            words      <= '0;
        end else begin
            state      <= state_next;
            tx_valid   <= tx_valid_next;
            tx_data    <= tx_data_next;
            busy       <= busy_next;
            boot_done  <= boot_done_next;
            size_error <= size_error_next;
            if (restart) begin
                size     <= '0;
                size_cnt <= '0;
                addr     <= '0;
                words    <= '0;
            end else begin
                if (state == RECV_SIZE && rx_valid) begin
                    size[8*size_cnt +: 8] <= rx_data;
                    size_cnt              <= size_cnt + 1'b1;
                end
                if (state == CHECK_SIZE) begin
                    words <= word_count[ADDR_WIDTH:0];
                end
                if (state == RECV_DATA && word_valid) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: little-endian, big-endian and 4-word-capacity
// instances share one stimulus stream; writes and tx bytes are logged per instance.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, rx_valid, tx_ready;
    logic [7:0] rx_data;

    logic        tx_valid   [3];
    logic [7:0]  tx_data    [3];
    logic        prog_we    [3];
    logic [11:0] prog_addr  [3];
    logic [31:0] prog_wdata [3];
    logic        busy       [3];
    logic        boot_done  [3];
    logic        size_error [3];
    logic [1:0]  small_addr;

    assign prog_addr[2] = {10'b0, small_addr};

    boot_loader #(.WORD_BYTES(4), .ADDR_WIDTH(12), .BIG_ENDIAN(1'b0),
                  .SYNC_BYTE(8'h99), .ACK_BYTE(8'hAA)) dut_le (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_wdata(prog_wdata[0]),
        .busy(busy[0]), .boot_done(boot_done[0]), .size_error(size_error[0]));

    boot_loader #(.WORD_BYTES(4), .ADDR_WIDTH(12), .BIG_ENDIAN(1'b1),
                  .SYNC_BYTE(8'h99), .ACK_BYTE(8'hAA)) dut_be (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_wdata(prog_wdata[1]),
        .busy(busy[1]), .boot_done(boot_done[1]), .size_error(size_error[1]));

    boot_loader #(.WORD_BYTES(4), .ADDR_WIDTH(2), .BIG_ENDIAN(1'b0),
                  .SYNC_BYTE(8'h99), .ACK_BYTE(8'hAA)) dut_small (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
        .prog_we(prog_we[2]), .prog_addr(small_addr), .prog_wdata(prog_wdata[2]),
        .busy(busy[2]), .boot_done(boot_done[2]), .size_error(size_error[2]));

    // Write/tx log, sampled on the falling edge
    int unsigned wr_cnt       [3] = '{0, 0, 0};
    int unsigned wr_idx       [3] = '{0, 0, 0};
    int unsigned idx_err      [3] = '{0, 0, 0};
    logic [31:0] wr_first     [3];
    logic [31:0] wr_last      [3];
    logic [11:0] wr_last_addr [3];
    logic [7:0]  tx_log [$];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset || start) begin
                wr_idx[d] = 0;
            end else if (prog_we[d]) begin
                if (prog_addr[d] != 12'(wr_idx[d])) idx_err[d]++;
                if (wr_idx[d] == 0) wr_first[d] = prog_wdata[d];
                wr_last[d]      = prog_wdata[d];
                wr_last_addr[d] = prog_addr[d];
                wr_cnt[d]++;
                wr_idx[d]++;
            end
        end
        if (tx_valid[0] && tx_ready) tx_log.push_back(tx_data[0]);
    end

    typedef struct {
        string       name;
        logic [31:0] size;
        int unsigned nbytes;
        logic [159:0] data;
        bit          err;
        int unsigned words;
        logic [31:0] le_first, le_last, be_first, be_last;
        bit          small_err;
        int unsigned small_words;
    } vec_t;

    vec_t vecs [5];
    int tests = 0;
    int fails = 0;
    int unsigned base_wr [3];
    int base_tx;

    function automatic vec_t mk(input string name, input logic [31:0] size, input int unsigned nbytes,
                                input logic [159:0] data, input bit err, input int unsigned words,
                                input logic [31:0] lf, input logic [31:0] ll,
                                input logic [31:0] bf, input logic [31:0] bl,
                                input bit serr, input int unsigned swords);
        vec_t v;
        v.name = name; v.size = size; v.nbytes = nbytes; v.data = data;
        v.err = err; v.words = words;
        v.le_first = lf; v.le_last = ll; v.be_first = bf; v.be_last = bl;
        v.small_err = serr; v.small_words = swords;
        return v;
    endfunction

    function automatic logic [7:0] txat(input int i);
        if (i >= 0 && i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic settle(input string name);
        int c = 0;
        while ((busy[0] || busy[1] || busy[2]) && c < 60) begin
            tick();
            c++;
        end
        check({name, ":settle"}, {29'b0, busy[0], busy[1], busy[2]}, 32'h0);
    endtask

    task automatic snapshot();
        for (int d = 0; d < 3; d++) base_wr[d] = wr_cnt[d];
        base_tx = tx_log.size();
    endtask

    task automatic send_size(input logic [31:0] size);
        for (int i = 0; i < 4; i++) send(size[8*i +: 8]);
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_boot(input vec_t v);
        snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        send_size(v.size);
        for (int i = 0; i < v.nbytes; i++) send(v.data[8*i +: 8]);
        rx_valid = 1'b0;
        settle(v.name);
    endtask

    task automatic check_boot(input vec_t v);
        int exp_tx = v.err ? 1 : 2;
        check({v.name, ":tx_count"}, 32'(tx_log.size() - base_tx), 32'(exp_tx));
        check({v.name, ":tx_sync"}, 32'(txat(base_tx)), 32'h99);
        if (!v.err) check({v.name, ":tx_ack"}, 32'(txat(base_tx + 1)), 32'hAA);
        check({v.name, ":flags"}, {30'b0, boot_done[0], size_error[0]}, {30'b0, !v.err, v.err});
        check({v.name, ":writes"}, wr_cnt[0] - base_wr[0], v.words);
        if (v.words > 0) begin
            check({v.name, ":le_first"}, wr_first[0], v.le_first);
            check({v.name, ":le_last"}, wr_last[0], v.le_last);
            check({v.name, ":le_last_addr"}, 32'(wr_last_addr[0]), v.words - 1);
            check({v.name, ":be_first"}, wr_first[1], v.be_first);
            check({v.name, ":be_last"}, wr_last[1], v.be_last);
        end
        check({v.name, ":small_flags"}, {30'b0, boot_done[2], size_error[2]},
              {30'b0, !v.small_err, v.small_err});
        check({v.name, ":small_writes"}, wr_cnt[2] - base_wr[2], v.small_words);
        if (v.small_words > 0)
            check({v.name, ":small_last_addr"}, 32'(wr_last_addr[2]), v.small_words - 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":ctl"}, {8'b0, tx_valid[0], tx_data[0], prog_we[0], prog_addr[0],
                               busy[0], boot_done[0], size_error[0]}, 32'h0);
        check({name, ":wdata"}, prog_wdata[0], 32'h0);
    endtask

    initial begin
        logic stable;

        vecs[0] = mk("two_words", 32'd8, 8, 160'h00100093_00000013, 1'b0, 2,
                     32'h00000013, 32'h00100093, 32'h13000000, 32'h93001000, 1'b0, 2);
        vecs[1] = mk("size6", 32'd6, 6, 160'h06_05_04_03_02_01, 1'b1, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        vecs[2] = mk("size0", 32'd0, 0, 160'h0, 1'b0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        vecs[3] = mk("four_words", 32'd16, 16, 160'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 4,
                     32'h03020100, 32'h0F0E0D0C, 32'h00010203, 32'h0C0D0E0F, 1'b0, 4);
        vecs[4] = mk("five_words", 32'd20, 20,
                     160'h23222120_1F1E1D1C_1B1A1918_17161514_13121110, 1'b0, 5,
                     32'h13121110, 32'h23222120, 32'h10111213, 32'h20212223, 1'b1, 0);

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        tick(); tick(); tick();
        check_reset_outputs("reset_state");
        reset = 1'b0;
        tick();

        // Back-to-back boots; each after the first restarts from DONE/ERROR
        for (int i = 0; i < 5; i++) begin
            run_boot(vecs[i]);
            check_boot(vecs[i]);
        end

        // Restart after a size error clears the flag and resends sync
        run_boot(vecs[1]);
        check_boot(vecs[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart:err_clear", {31'b0, size_error[0]}, 32'h0);
        check("restart:sync", {23'b0, tx_valid[0], tx_data[0]}, {23'b0, 1'b1, 8'h99});

        // Sync held while tx_ready is low; rx bytes in that window are dropped
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        tx_ready = 1'b0;
        snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(tx_valid[0] === 1'b1 && tx_data[0] === 8'h99)) stable = 1'b0;
            rx_valid = 1'b1;
            rx_data  = 8'h08;
            tick();
        end
        rx_valid = 1'b0;
        check("stall:held", {31'b0, stable}, 32'h1);
        check("stall:no_tx", 32'(tx_log.size() - base_tx), 32'h0);
        tx_ready = 1'b1;
        tick();
        tick();
        check("stall:one_tx", 32'(tx_log.size() - base_tx), 32'h1);
        send_size(32'd0);
        settle("stall");
        check("stall:done", {31'b0, boot_done[0]}, 32'h1);
        check("stall:tx_total", 32'(tx_log.size() - base_tx), 32'h2);
        check("stall:writes", wr_cnt[0] - base_wr[0], 32'h0);

        // Reset mid-image after two of four words, then a full fresh boot
        reset = 1'b1; tick(); reset = 1'b0;
        snapshot();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        send_size(32'd16);
        for (int i = 0; i < 8; i++) send(8'(i));
        rx_valid = 1'b0;
        tick();
        check("midreset:two_words", wr_cnt[0] - base_wr[0], 32'h2);
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick();
        run_boot(vecs[3]);
        check_boot(vecs[3]);

        check("addr_sequence", idx_err[0] + idx_err[1] + idx_err[2], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
